// File: rtl/sha_round_sched_if.sv
// Bundle between the SHA-256 round controller, its work feed, the external
// round datapath and the digest consumer. master = controller side.
interface sha_round_sched_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_i;
  logic [255:0] hash_i;
  logic [255:0] round_in;
  logic [31:0]  round_K;
  logic [31:0]  round_W;
  logic [255:0] round_out;
  logic [255:0] hash_o;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [1:0]   state_dbg;

  modport master (
    input  in_valid, block_i, hash_i, round_out, out_ready,
    output in_ready, round_in, round_K, round_W, hash_o, out_valid, busy, state_dbg
  );

  modport slave (
    output in_valid, block_i, hash_i, round_out, out_ready,
    input  in_ready, round_in, round_K, round_W, hash_o, out_valid, busy, state_dbg
  );
endinterface

// File: rtl/sha_round_sched.sv
// Iterative SHA-256 compression controller driving an external registered round datapath.
// Optional abort input enabled by defining SHA_ROUND_SCHED_ABORT_EN.
module sha_round_sched #(
  parameter int NROUNDS = 64
) (
  input logic clk,
  input logic rst,
`ifdef SHA_ROUND_SCHED_ABORT_EN
  input logic abort,
`endif
  sha_round_sched_if.master bus
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t       state, state_n;
  logic [5:0]   t;
  logic [31:0]  w [16];
  logic [255:0] h_reg;
  logic [255:0] hash_q;
  logic         out_valid_q;
  logic         abort_hit;
  logic [31:0]  w_next;
  logic [255:0] dm_sum;

`ifdef SHA_ROUND_SCHED_ABORT_EN
  assign abort_hit = abort && (state == RUN || state == ADD);
`else
  assign abort_hit = 1'b0;
`endif

  assign w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  // Davies-Meyer feed-forward: eight independent 32-bit adds.
  always_comb begin
    dm_sum = '0;
    for (int i = 0; i < 8; i++) begin
      dm_sum[32*i +: 32] = h_reg[32*i +: 32] + bus.round_out[32*i +: 32];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) state_n = RUN;
      RUN:  if (t == 6'(NROUNDS - 1)) state_n = ADD;
      ADD:  state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      t           <= '0;
      h_reg       <= '0;
      hash_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            h_reg <= bus.hash_i;
            t     <= '0;
            for (int i = 0; i < 16; i++) w[i] <= bus.block_i[511 - 32*i -: 32];
          end
        end
        RUN: begin
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_next;
          t     <= t + 6'd1;
        end
        ADD: begin
          if (!abort_hit) begin
            hash_q      <= dm_sum;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
      if (abort_hit) t <= '0;
    end
  end

  // Round 0 starts from the chaining value; later rounds chain the datapath result.
  always_comb begin
    bus.round_in = '0;
    bus.round_K  = '0;
    bus.round_W  = '0;
    if (state == RUN) begin
      bus.round_in = (t == '0) ? h_reg : bus.round_out;
      bus.round_K  = K_ROM[t];
      bus.round_W  = w[0];
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN) || (state == ADD);
  assign bus.hash_o    = hash_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_dbg = state;

endmodule
